// File: rtl/ball_motion.sv
// Ball kinematics for the Breakout playfield: owns the ball centre, reflects it
// off walls, paddle and bricks once per frame, and sequences serve/play/lost/over
// together with the lives count.
module ball_motion #(
   parameter int H_SIZE      = 3,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int SPEED       = 1,
   parameter int PADDLE_Y    = 460,
   parameter int PADDLE_HALF = 20,
   parameter int LIVES       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       launch,
   input  logic [9:0] paddle_x,
   input  logic       brick_hit,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic       in_play,
   output logic       ball_lost,
   output logic [1:0] lives,
   output logic       game_over
);

   typedef enum logic [1:0] {SERVE, PLAY, LOST, OVER} state_t;

   // Motion arithmetic is 11-bit signed so a step past zero stays negative.
   localparam logic signed [10:0] HS     = 11'(H_SIZE);
   localparam logic signed [10:0] SPD    = 11'(SPEED);
   localparam logic signed [10:0] BOT    = 11'(SCREEN_H - 1);
   localparam logic signed [10:0] RIGHT  = 11'(SCREEN_W - 1);
   localparam logic signed [10:0] PAD_Y  = 11'(PADDLE_Y);
   localparam logic signed [10:0] REACH  = 11'(PADDLE_HALF + H_SIZE);
   localparam logic [9:0]         X_LO   = 10'(H_SIZE);
   localparam logic [9:0]         X_HI   = 10'(SCREEN_W - 1 - H_SIZE);
   localparam logic [9:0]         X_HOME = 10'(SCREEN_W / 2);
   localparam logic [8:0]         Y_TOP  = 9'(H_SIZE);
   localparam logic [8:0]         Y_REST = 9'(PADDLE_Y - H_SIZE - 1);
   localparam logic [1:0]         LIVES0 = 2'(LIVES);

   state_t state, state_next;

   logic       dx_left;      // 1: moving left (dx = -1)
   logic       dy_up;        // 1: moving up   (dy = -1)
   logic       pending_hit;

   logic signed [10:0] x_s, y_s, p_s, nx, ny;
   logic               flip, up_eff, at_bottom;
   logic [9:0]         x_next;
   logic [8:0]         y_next;
   logic               left_next, up_next;
   logic [1:0]         lives_dec;

   function automatic logic [9:0] clamp_x(input logic [9:0] p);
      if (p < X_LO)      return X_LO;
      else if (p > X_HI) return X_HI;
      else               return p;
   endfunction

   function automatic logic signed [10:0] mag(input logic signed [10:0] v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [1:0] dec_sat(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   assign lives_dec = dec_sat(lives);

   // Candidate next position and reflections for the coming frame_tick.
   always_comb begin
      x_s       = signed'({1'b0, ball_x});
      y_s       = signed'({2'b00, ball_y});
      p_s       = signed'({1'b0, paddle_x});
      // A hit arriving on the tick itself is consumed by that tick.
      flip      = pending_hit | brick_hit;
      up_eff    = dy_up ^ flip;
      nx        = dx_left ? (x_s - SPD) : (x_s + SPD);
      ny        = up_eff  ? (y_s - SPD) : (y_s + SPD);
      at_bottom = (ny + HS) >= BOT;

      // Paddle only catches a ball that was falling before any brick flip.
      if ((ny - HS) <= 11'sd0) begin
         y_next  = Y_TOP;
         up_next = 1'b0;
      end else if (!dy_up && ((ny + HS) >= PAD_Y) && (mag(nx - p_s) <= REACH)) begin
         y_next  = Y_REST;
         up_next = 1'b1;
      end else begin
         y_next  = ny[8:0];
         up_next = up_eff;
      end

      if ((nx - HS) <= 11'sd0) begin
         x_next    = X_LO;
         left_next = 1'b0;
      end else if ((nx + HS) >= RIGHT) begin
         x_next    = X_HI;
         left_next = 1'b1;
      end else begin
         x_next    = nx[9:0];
         left_next = dx_left;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= SERVE;
      else       state <= state_next;
   end

   // Next-state decision.
   always_comb begin
      state_next = state;
      case (state)
         SERVE:   if (launch) state_next = PLAY;
         PLAY:    if (frame_tick && at_bottom) state_next = LOST;
         LOST:    state_next = (lives_dec == 2'd0) ? OVER : SERVE;
         default: state_next = OVER;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      in_play   = (state == PLAY);
      ball_lost = (state == LOST);
      game_over = (state == OVER);
   end

   // Ball position, direction, pending brick hit and lives.
   always_ff @(posedge clk) begin
      if (reset) begin
         ball_x      <= X_HOME;
         ball_y      <= Y_REST;
         dx_left     <= 1'b0;
         dy_up       <= 1'b1;
         pending_hit <= 1'b0;
         lives       <= LIVES0;
      end else begin
         case (state)
            SERVE: begin
               ball_x      <= clamp_x(paddle_x);
               ball_y      <= Y_REST;
               dx_left     <= 1'b0;
               dy_up       <= 1'b1;
               pending_hit <= 1'b0;
            end
            PLAY: begin
               if (frame_tick) begin
                  pending_hit <= 1'b0;
                  if (!at_bottom) begin
                     ball_x  <= x_next;
                     ball_y  <= y_next;
                     dx_left <= left_next;
                     dy_up   <= up_next;
                  end
               end else if (brick_hit) begin
                  pending_hit <= 1'b1;
               end
            end
            LOST: begin
               lives       <= lives_dec;
               pending_hit <= 1'b0;
            end
            default: pending_hit <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed vector table, hand-written corner sequences,
// then randomized stimulus against a behavioural model.
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       reset, frame_tick, launch, brick_hit;
   logic [9:0] paddle_x;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       in_play, ball_lost, game_over;
   logic [1:0] lives;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ball_motion dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
      .paddle_x(paddle_x), .brick_hit(brick_hit), .ball_x(ball_x), .ball_y(ball_y),
      .in_play(in_play), .ball_lost(ball_lost), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        tick;
      logic        lau;
      logic        bh;
      logic [9:0]  px;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [23:0] pk(int x, int y, bit play, bit lost, int lv, bit over);
      return {10'(x), 9'(y), play, lost, 2'(lv), over};
   endfunction

   function automatic string fmt(logic [23:0] v);
      return $sformatf("x=%0d y=%0d play=%0b lost=%0b lives=%0d over=%0b",
                       v[23:14], v[13:5], v[4], v[3], v[2:1], v[0]);
   endfunction

   task automatic chk(input string name, input logic [23:0] exp);
      logic [23:0] act;
      act = {ball_x, ball_y, in_play, ball_lost, lives, game_over};
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic cyc(input bit rst, input bit tick, input bit lau, input bit bh, input int px);
      reset      = rst;
      frame_tick = tick;
      launch     = lau;
      brick_hit  = bh;
      paddle_x   = 10'(px);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input bit rst, input bit tick, input bit lau, input bit bh,
                      input int px, input logic [23:0] exp);
      vecs.push_back('{rst: rst, tick: tick, lau: lau, bh: bh, px: 10'(px), exp: exp});
   endtask

   // Behavioural reference model: integer position, +/-1 velocities.
   int m_st, m_x, m_y, m_dx, m_dy, m_lives;   // m_st: 0 serve, 1 play, 2 lost, 3 over
   bit m_pend;

   task automatic model_step(input bit rst, input bit tick, input bit lau, input bit bh, input int px);
      int nx, ny, d;
      bit f;
      if (rst) begin
         m_st = 0; m_x = 320; m_y = 456; m_dx = 1; m_dy = -1; m_lives = 3; m_pend = 0;
         return;
      end
      case (m_st)
         0: begin
            m_x = (px < 3) ? 3 : ((px > 636) ? 636 : px);
            m_y = 456; m_dx = 1; m_dy = -1; m_pend = 0;
            if (lau) m_st = 1;
         end
         1: begin
            if (tick) begin
               f  = m_pend || bh;
               d  = f ? -m_dy : m_dy;
               nx = m_x + m_dx;
               ny = m_y + d;
               m_pend = 0;
               if (ny + 3 >= 479) m_st = 2;
               else begin
                  if (ny - 3 <= 0) begin m_y = 3; m_dy = 1; end
                  else if (m_dy == 1 && ny + 3 >= 460 && nx - px <= 23 && px - nx <= 23) begin
                     m_y = 456; m_dy = -1;
                  end else begin m_y = ny; m_dy = d; end
                  if (nx - 3 <= 0) begin m_x = 3; m_dx = 1; end
                  else if (nx + 3 >= 639) begin m_x = 636; m_dx = -1; end
                  else m_x = nx;
               end
            end else if (bh) m_pend = 1;
         end
         2: begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_st    = (m_lives == 0) ? 3 : 0;
         end
         default: ;
      endcase
   endtask

   // Serve, flip the ball downward with a brick hit, then miss the paddle.
   task automatic lose_life(input int lv_before);
      cyc(0, 0, 1, 0, 100);
      cyc(0, 1, 0, 1, 500);
      chk($sformatf("lose%0d_flip", lv_before), pk(101, 457, 1, 0, lv_before, 0));
      for (int i = 0; i < 19; i++) cyc(0, 1, 0, 0, 500);
      chk($sformatf("lose%0d_pulse", lv_before), pk(119, 475, 0, 1, lv_before, 0));
      cyc(0, 0, 0, 0, 100);
      chk($sformatf("lose%0d_after", lv_before),
          pk(119, 475, 0, 0, lv_before - 1, (lv_before - 1) == 0));
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; launch = 1'b0; brick_hit = 1'b0; paddle_x = 10'd0;

      // Serve clamping, launch and first moves, reset mid-play, right wall.
      add(1, 0, 0, 0, 100, pk(320, 456, 0, 0, 3, 0));
      add(0, 0, 0, 0, 100, pk(100, 456, 0, 0, 3, 0));
      add(0, 0, 0, 0,   1, pk(  3, 456, 0, 0, 3, 0));
      add(0, 0, 0, 0, 700, pk(636, 456, 0, 0, 3, 0));
      add(0, 0, 1, 0, 320, pk(320, 456, 1, 0, 3, 0));
      add(0, 0, 0, 0, 320, pk(320, 456, 1, 0, 3, 0));
      add(0, 1, 0, 0, 320, pk(321, 455, 1, 0, 3, 0));
      add(0, 0, 0, 0, 320, pk(321, 455, 1, 0, 3, 0));
      add(0, 1, 0, 0, 320, pk(322, 454, 1, 0, 3, 0));
      add(0, 1, 0, 0, 320, pk(323, 453, 1, 0, 3, 0));
      add(0, 0, 1, 0, 900, pk(323, 453, 1, 0, 3, 0));
      add(1, 1, 0, 0, 320, pk(320, 456, 0, 0, 3, 0));
      add(0, 0, 0, 0, 630, pk(630, 456, 0, 0, 3, 0));
      add(0, 0, 1, 0, 630, pk(630, 456, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(631, 455, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(632, 454, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(633, 453, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(634, 452, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(635, 451, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(636, 450, 1, 0, 3, 0));
      add(0, 1, 0, 0, 630, pk(635, 449, 1, 0, 3, 0));
      add(1, 0, 0, 0, 320, pk(320, 456, 0, 0, 3, 0));

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].tick, vecs[i].lau, vecs[i].bh, int'(vecs[i].px));
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Brick hits, paddle catch at the reach limit, paddle miss and loss.
      cyc(0, 0, 0, 0, 320);
      cyc(0, 0, 1, 0, 320);
      for (int i = 0; i < 56; i++) cyc(0, 1, 0, 0, 320);
      chk("climb", pk(376, 400, 1, 0, 3, 0));
      cyc(0, 0, 0, 1, 320);
      cyc(0, 0, 0, 0, 320);
      cyc(0, 0, 0, 1, 320);
      chk("hit_hold", pk(376, 400, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 320);
      chk("hit_single_flip", pk(377, 401, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 320);
      chk("hit_cleared", pk(378, 402, 1, 0, 3, 0));
      for (int i = 0; i < 54; i++) cyc(0, 1, 0, 0, 320);
      chk("fall", pk(432, 456, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 410);
      chk("paddle_catch", pk(433, 456, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 410);
      chk("paddle_up", pk(434, 455, 1, 0, 3, 0));
      cyc(0, 1, 0, 1, 410);
      chk("hit_on_tick", pk(435, 456, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 406);
      chk("paddle_miss", pk(436, 457, 1, 0, 3, 0));
      for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0, 406);
      chk("near_bottom", pk(454, 475, 1, 0, 3, 0));
      cyc(0, 1, 0, 0, 406);
      chk("lost_pulse", pk(454, 475, 0, 1, 3, 0));
      cyc(0, 0, 0, 0, 200);
      chk("lost_after", pk(454, 475, 0, 0, 2, 0));
      cyc(0, 0, 0, 0, 200);
      chk("reserve", pk(200, 456, 0, 0, 2, 0));

      // Remaining lives, game over, launch ignored, reset exit.
      lose_life(2);
      lose_life(1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 300);
      chk("over_hold", pk(119, 475, 0, 0, 0, 1));
      cyc(1, 0, 0, 0, 300);
      chk("over_reset", pk(320, 456, 0, 0, 3, 0));

      // Randomized run against the model.
      model_step(1, 0, 0, 0, 320);
      cyc(1, 0, 0, 0, 320);
      chk("rand_reset", pk(m_x, m_y, m_st == 1, m_st == 2, m_lives, m_st == 3));
      for (int n = 0; n < 4000; n++) begin
         bit rst, tick, lau, bh;
         int px;
         rst  = ($urandom_range(0, 399) == 0);
         tick = ($urandom_range(0, 1) == 1);
         lau  = ($urandom_range(0, 7) == 0);
         bh   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1) px = m_x + $urandom_range(0, 60) - 30;
         else px = $urandom_range(0, 1023);
         if (px < 0) px = 0;
         if (px > 1023) px = 1023;
         model_step(rst, tick, lau, bh, px);
         cyc(rst, tick, lau, bh, px);
         chk($sformatf("rand%0d", n), pk(m_x, m_y, m_st == 1, m_st == 2, m_lives, m_st == 3));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
